// File: rtl/power_guard_mc.sv
// rtl/power_guard_mc.sv - multi-rail power guard: path check, timed/instant overcurrent trip, cooldown retry, fuse
// Optional feature macro: POWER_GUARD_STAT_EN (adds per-rail saturating trip counters on trip_total)
module power_guard_mc #(
  parameter int NCH       = 4,
  parameter int CUR_W     = 12,
  parameter int LIMIT_MA  = 500,
  parameter int SHORT_MA  = 2000,
  parameter int TRIP_CYC  = 16,
  parameter int COOL_CYC  = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NCH-1:0]                    ch_en,
  input  logic [NCH-1:0]                    polarity_rev,
  input  logic [NCH-1:0]                    diode_blown,
  input  logic [NCH-1:0]                    diode_shorted,
  input  logic [NCH*CUR_W-1:0]              cur_ma,
  input  logic [NCH-1:0]                    force_blow,
  input  logic [NCH-1:0]                    rearm,
  output logic [NCH-1:0]                    powered,
  output logic [NCH-1:0]                    fuse_blown,
  output logic [NCH*2-1:0]                  retry_cnt,
  output logic [CUR_W+$clog2(NCH)-1:0]      total_ma,
  output logic                              any_fault
`ifdef POWER_GUARD_STAT_EN
  ,
  output logic [NCH*8-1:0]                  trip_total
`endif
);

  localparam int SUM_W = CUR_W + $clog2(NCH);
  localparam int OC_W  = $clog2(TRIP_CYC + 1);
  localparam int CL_W  = $clog2(COOL_CYC + 1);

  typedef enum logic [2:0] {S_OFF, S_ON, S_OVER, S_COOL, S_BLOWN} state_t;

  state_t            state    [NCH];
  state_t            state_nx [NCH];
  logic [OC_W-1:0]   over_cnt [NCH];
  logic [OC_W-1:0]   over_nx  [NCH];
  logic [CL_W-1:0]   cool_cnt [NCH];
  logic [CL_W-1:0]   cool_nx  [NCH];
  logic [1:0]        retry    [NCH];
  logic [1:0]        retry_nx [NCH];
  logic              trip     [NCH];
  logic              trip_ev  [NCH];
  logic [CUR_W-1:0]  cur      [NCH];
  logic              path_ok  [NCH];
  logic [SUM_W-1:0]  sum_nx;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign cur[g]     = cur_ma[g*CUR_W +: CUR_W];
    // A shorted failed diode still conducts; otherwise need an intact diode and correct polarity
    assign path_ok[g] = (diode_blown[g] & diode_shorted[g]) | (~diode_blown[g] & ~polarity_rev[g]);
    assign powered[g]    = (state[g] == S_ON) || (state[g] == S_OVER);
    assign fuse_blown[g] = (state[g] == S_BLOWN);
    assign retry_cnt[2*g +: 2] = retry[g];
  end

  assign any_fault = |fuse_blown;

  // Next-state, counters and trip resolution for every rail
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_nx[i] = state[i];
      over_nx[i]  = over_cnt[i];
      cool_nx[i]  = cool_cnt[i];
      retry_nx[i] = retry[i];
      trip[i]     = 1'b0;
      trip_ev[i]  = 1'b0;
      if (force_blow[i]) begin
        state_nx[i] = S_BLOWN;
        over_nx[i]  = '0;
        cool_nx[i]  = '0;
        trip_ev[i]  = 1'b1;
      end else begin
        case (state[i])
          S_BLOWN: begin
            if (rearm[i]) begin
              state_nx[i] = S_OFF;
              retry_nx[i] = '0;
            end
          end
          S_OFF: begin
            if (!ch_en[i]) retry_nx[i] = '0;
            else if (path_ok[i]) state_nx[i] = S_ON;
          end
          S_ON, S_OVER: begin
            if (!ch_en[i] || !path_ok[i]) begin
              state_nx[i] = S_OFF;
              over_nx[i]  = '0;
            end else if (int'(cur[i]) >= SHORT_MA) begin
              trip[i] = 1'b1;
            end else if (int'(cur[i]) > LIMIT_MA) begin
              if (int'(over_cnt[i]) + 1 >= TRIP_CYC) begin
                trip[i] = 1'b1;
              end else begin
                state_nx[i] = S_OVER;
                over_nx[i]  = over_cnt[i] + OC_W'(1);
              end
            end else begin
              state_nx[i] = S_ON;
              over_nx[i]  = '0;
            end
          end
          S_COOL: begin
            cool_nx[i] = cool_cnt[i] - CL_W'(1);
            if (cool_cnt[i] == CL_W'(1)) state_nx[i] = S_OFF;
          end
          default: state_nx[i] = S_OFF;
        endcase
        if (trip[i]) begin
          trip_ev[i]  = 1'b1;
          over_nx[i]  = '0;
          retry_nx[i] = retry[i] + 2'd1;
          if (int'(retry[i]) + 1 >= MAX_RETRY) begin
            state_nx[i] = S_BLOWN;
          end else begin
            state_nx[i] = S_COOL;
            cool_nx[i]  = CL_W'(COOL_CYC);
          end
        end
      end
    end
  end

  // Aggregate current of rails conducting this cycle
  always_comb begin
    sum_nx = '0;
    for (int i = 0; i < NCH; i++) begin
      if ((state[i] == S_ON) || (state[i] == S_OVER)) sum_nx = sum_nx + SUM_W'(cur[i]);
    end
  end

  // Per-rail state, timers, retry count and total current registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state[i]    <= S_OFF;
        over_cnt[i] <= '0;
        cool_cnt[i] <= '0;
        retry[i]    <= '0;
      end
      total_ma <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state[i]    <= state_nx[i];
        over_cnt[i] <= over_nx[i];
        cool_cnt[i] <= cool_nx[i];
        retry[i]    <= retry_nx[i];
      end
      total_ma <= sum_nx;
    end
  end

`ifdef POWER_GUARD_STAT_EN
  logic [7:0] trip_tot [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_stat
    assign trip_total[8*g +: 8] = trip_tot[g];
  end

  // Lifetime trip counters, saturating, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) trip_tot[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (trip_ev[i] && (trip_tot[i] != 8'hff)) trip_tot[i] <= trip_tot[i] + 8'd1;
      end
    end
  end
`endif

endmodule
